// File: rtl/ahb_sram_4kx32_ctrl.sv
// AHB-Lite slave for a 4Kx32 two-port SRAM: sub-word writes via RMW, write-to-read forwarding.
// Define AHB_SRAM_ALIGN_CHK_EN to answer misaligned transfers with a two-cycle ERROR.
module ahb_sram_4kx32_ctrl #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [DW-1:0] HRDATA,
  output logic [DW-1:0] sram_wd,
  output logic [AW-1:0] sram_waddr,
  output logic          sram_wen,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rd
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    ERR1,
    ERR2
  } state_t;

  state_t state, nxt;

  logic [AW-1:0] addr_r;
  logic [1:0]    off_r;
  logic [2:0]    size_r;
  logic          wr_r;

  logic          fwd_vld;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
  logic          fwd_hit;

  logic          accept;
  logic          hold;
  logic          acc;
  logic          full_word;
  logic          misal;
  logic [3:0]    mask;
  logic [DW-1:0] old_word;
  logic [DW-1:0] merged;

  logic unused;
  assign unused = ^{HADDR[31:AW+2], HTRANS[0]};

  assign accept    = HSEL & HTRANS[1] & HREADY;
  // RMW_RD and ERR1 advance regardless of HREADY and must not latch a new address
  assign hold      = (state == RMW_RD) | (state == ERR1);
  assign acc       = accept & ~hold;
  assign full_word = (HSIZE >= 3'd2);

`ifdef AHB_SRAM_ALIGN_CHK_EN
  assign misal = ((HSIZE == 3'd1) & HADDR[0])
               | ((HSIZE == 3'd2) & (|HADDR[1:0]))
               | (HSIZE > 3'd2);
`else
  assign misal = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (state == RMW_RD)      nxt = RMW_WR;
    else if (state == ERR1)   nxt = ERR2;
    else if (HREADY) begin
      if (!accept)            nxt = IDLE;
      else if (misal)         nxt = ERR1;
      else if (!HWRITE)       nxt = RD;
      else if (full_word)     nxt = WR;
      else                    nxt = RMW_RD;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_r <= '0;
      off_r  <= '0;
      size_r <= '0;
      wr_r   <= 1'b0;
    end else if (acc) begin
      addr_r <= HADDR[AW+1:2];
      off_r  <= HADDR[1:0];
      size_r <= HSIZE;
      wr_r   <= HWRITE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_vld  <= 1'b0;
      fwd_addr <= '0;
      fwd_data <= '0;
    end else begin
      fwd_vld <= sram_wen;
      if (sram_wen) begin
        fwd_addr <= sram_waddr;
        fwd_data <= sram_wd;
      end
    end
  end

  // every consumed read (RD or RMW_WR) belongs to the registered address
  assign fwd_hit  = fwd_vld & (fwd_addr == addr_r);
  assign old_word = fwd_hit ? fwd_data : sram_rd;

  always_comb begin
    unique case (size_r)
      3'd0:    mask = 4'b0001 << off_r;
      3'd1:    mask = off_r[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) merged[8*k +: 8] = HWDATA[8*k +: 8];
    end
  end

  assign sram_waddr = addr_r;

  always_comb begin
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    HRDATA     = '0;
    sram_wen   = 1'b0;
    sram_wd    = '0;
    sram_raddr = HADDR[AW+1:2];
    unique case (state)
      RD: HRDATA = old_word;
      WR: begin
        sram_wen = wr_r;
        sram_wd  = HWDATA;
      end
      RMW_RD: begin
        HREADYOUT  = 1'b0;
        sram_raddr = addr_r;
      end
      RMW_WR: begin
        sram_wen = wr_r;
        sram_wd  = merged;
      end
`ifdef AHB_SRAM_ALIGN_CHK_EN
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2: HRESP = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_4kx32_ctrl.sv
// Directed bench for ahb_sram_4kx32_ctrl with a behavioural SRAM and read-data scoreboard.
// Covers zero-wait paths, RMW, forwarding, reset mid-RMW and the alignment option.
module tb_ahb_sram_4kx32_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] sram_wd;
  logic [11:0] sram_waddr;
  logic        sram_wen;
  logic [11:0] sram_raddr;
  logic [31:0] sram_rd;

  ahb_sram_4kx32_ctrl dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .sram_wd    (sram_wd),
    .sram_waddr (sram_waddr),
    .sram_wen   (sram_wen),
    .sram_raddr (sram_raddr),
    .sram_rd    (sram_rd)
  );

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT;

  logic [31:0] mem [4096];

  always @(posedge HCLK) begin
    if (sram_wen) mem[sram_waddr] <= sram_wd;
    sram_rd <= mem[sram_raddr];
  end

  int          total = 0;
  int          fails = 0;
  logic [31:0] exp_q [$];
  bit          dp_rd;
  logic [31:0] pend_wd;
  int          last_waits;
  logic        last_resp;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one address phase; completes the data phase of the previous one.
  task automatic xfer(input bit vld, input bit wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] d);
    int n;
    logic [31:0] e;
    n      = 0;
    HSEL   = vld;
    HTRANS = vld ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = a;
    HSIZE  = sz;
    HWDATA = pend_wd;
    @(negedge HCLK);
    while (!HREADYOUT && n < 8) begin
      n++;
      @(negedge HCLK);
    end
    if (!HREADYOUT) begin
      total++;
      fails++;
      $display("FAIL timeout at %h: HREADYOUT 0, required 1", a);
    end
    last_waits = n;
    last_resp  = HRESP;
    if (dp_rd) begin
      if (exp_q.size() == 0) begin
        total++;
        fails++;
        $display("FAIL scoreboard: read data %h with no expected value", HRDATA);
      end else begin
        e = exp_q.pop_front();
        check("rdata", HRDATA, e);
      end
    end
    @(posedge HCLK);
    #1;
    dp_rd   = vld && !wr;
    pend_wd = d;
    if (vld && !wr) exp_q.push_back(d);
  endtask

  task automatic idle();
    xfer(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  initial begin
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HTRANS  = 2'b00;
    HWRITE  = 1'b0;
    HADDR   = '0;
    HSIZE   = '0;
    HWDATA  = '0;
    pend_wd = '0;
    dp_rd   = 1'b0;
    #12;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_wen", 32'(sram_wen), 32'd0);
    check("rst_wd", sram_wd, 32'h0);
    check("rst_waddr", 32'(sram_waddr), 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    xfer(1, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    xfer(1, 0, 32'h10, 3'd2, 32'hDEADBEEF);
    check("word_wr_waits", 32'(last_waits), 32'd0);
    idle();
    check("word_rd_waits", 32'(last_waits), 32'd0);

    xfer(1, 1, 32'h20, 3'd2, 32'h11223344);
    xfer(1, 1, 32'h22, 3'd0, 32'h00AA0000);
    idle();
    check("byte_rmw_waits", 32'(last_waits), 32'd1);
    xfer(1, 0, 32'h20, 3'd2, 32'h11AA3344);
    idle();

    xfer(1, 1, 32'h40, 3'd2, 32'hFFFFFFFF);
    idle();
    xfer(1, 1, 32'h40, 3'd2, 32'h12345678);
    xfer(1, 0, 32'h40, 3'd2, 32'h12345678);
    idle();

    xfer(1, 1, 32'h30, 3'd2, 32'h0);
    idle();
    xfer(1, 1, 32'h32, 3'd1, 32'hBEEF0000);
    xfer(1, 1, 32'h30, 3'd1, 32'h0000CAFE);
    check("hw1_waits", 32'(last_waits), 32'd1);
    idle();
    check("hw2_waits", 32'(last_waits), 32'd1);
    xfer(1, 0, 32'h30, 3'd2, 32'hBEEFCAFE);
    idle();

    xfer(1, 1, 32'h50, 3'd2, 32'h0);
    idle();
    xfer(1, 1, 32'h50, 3'd0, 32'h000000BB);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWDATA = pend_wd;
    #2;
    HRESETn = 1'b0;
    #1;
    check("rmw_rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rmw_rst_wen", 32'(sram_wen), 32'd0);
    check("rmw_rst_wd", sram_wd, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      check("rmw_rst_wen_hold", 32'(sram_wen), 32'd0);
    end
    HRESETn = 1'b1;
    dp_rd   = 1'b0;
    pend_wd = '0;
    @(posedge HCLK);
    #1;
    xfer(1, 0, 32'h50, 3'd2, 32'h0);
    idle();
    check("rmw_rst_mem", mem[20], 32'h0);

    xfer(1, 1, 32'h60, 3'd2, 32'h0);
    idle();
    xfer(1, 1, 32'h62, 3'd2, 32'hA5A5A5A5);
`ifdef AHB_SRAM_ALIGN_CHK_EN
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWDATA = pend_wd;
    @(negedge HCLK);
    check("err1_hreadyout", 32'(HREADYOUT), 32'd0);
    check("err1_hresp", 32'(HRESP), 32'd1);
    check("err1_wen", 32'(sram_wen), 32'd0);
    @(negedge HCLK);
    check("err2_hreadyout", 32'(HREADYOUT), 32'd1);
    check("err2_hresp", 32'(HRESP), 32'd1);
    check("err2_wen", 32'(sram_wen), 32'd0);
    @(posedge HCLK);
    #1;
    dp_rd   = 1'b0;
    pend_wd = '0;
    xfer(1, 0, 32'h60, 3'd2, 32'h0);
    idle();
    check("misal_mem", mem[24], 32'h0);
`else
    xfer(1, 0, 32'h60, 3'd2, 32'hA5A5A5A5);
    check("misal_waits", 32'(last_waits), 32'd0);
    check("misal_hresp", 32'(last_resp), 32'd0);
    idle();
    check("misal_mem", mem[24], 32'hA5A5A5A5);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
